// File: rtl/ssio_sdr_in_deskew_if.sv
// Bus bundle for the deskewing SDR receiver: pad data, delay configuration
// handshake, training control and the deskewed, qualified output.
interface ssio_sdr_in_deskew_if #(
  parameter int CHANNELS    = 4,
  parameter int LANE_WIDTH  = 2,
  parameter int DELAY_WIDTH = 3
);
  logic [CHANNELS*LANE_WIDTH-1:0]  input_d;
  logic [CHANNELS*DELAY_WIDTH-1:0] cfg_delay;
  logic                            cfg_valid;
  logic                            cfg_ready;
  logic                            train_en;
  logic [CHANNELS*LANE_WIDTH-1:0]  output_q;
  logic                            output_valid;
  logic                            locked;
  logic [7:0]                      err_count;

  modport master (
    output input_d, cfg_delay, cfg_valid, train_en,
    input  cfg_ready, output_q, output_valid, locked, err_count
  );

  modport slave (
    input  input_d, cfg_delay, cfg_valid, train_en,
    output cfg_ready, output_q, output_valid, locked, err_count
  );
endinterface

// File: rtl/ssio_sdr_in_deskew.sv
// Source-synchronous SDR input: pad capture, per-lane programmable delay,
// delay-load handshake with a settle window, and training-pattern lock detect.
module ssio_sdr_in_deskew #(
  parameter string                 TARGET        = "GENERIC",
  parameter int                    CHANNELS      = 4,
  parameter int                    LANE_WIDTH    = 2,
  parameter int                    DELAY_WIDTH   = 3,
  parameter logic [LANE_WIDTH-1:0] TRAIN_PATTERN = 2'b10,
  parameter int                    LOCK_COUNT    = 16
) (
  input  logic                     input_clk,
  input  logic                     rst_n,
  output logic                     output_clk,
  ssio_sdr_in_deskew_if.slave      bus
);

  localparam int BUS_W  = CHANNELS * LANE_WIDTH;
  localparam int DMAX   = (1 << DELAY_WIDTH) - 1;
  localparam int SETTLE = (1 << DELAY_WIDTH) + 2;
  localparam int CNT_W  = DELAY_WIDTH + 1;
  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE - 1);
  localparam logic [7:0]       LOCK_MAX    = 8'(LOCK_COUNT);

  if (TARGET != "SIM" && TARGET != "GENERIC" && TARGET != "XILINX" && TARGET != "ALTERA") begin : g_bad_target
    $error("ssio_sdr_in_deskew: unsupported TARGET");
  end
  if (LOCK_COUNT < 1 || LOCK_COUNT > 255) begin : g_bad_lock
    $error("ssio_sdr_in_deskew: LOCK_COUNT out of range 1..255");
  end

  typedef enum logic {IDLE, SETTLE_ST} state_t;

  (* IOB = "TRUE" *) logic [BUS_W-1:0] cap_q;
  logic [BUS_W-1:0]       cap_d;
  logic [BUS_W-1:0]       line_q [DMAX];
  logic [BUS_W-1:0]       line_d [DMAX];
  logic [BUS_W-1:0]       tap_w  [DMAX+1];
  logic [BUS_W-1:0]       out_q, out_d;
  logic [DELAY_WIDTH-1:0] delay_q [CHANNELS];
  logic [DELAY_WIDTH-1:0] delay_d [CHANNELS];
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       settle_cnt_q, settle_cnt_d;
  logic [7:0]             match_cnt_q, match_cnt_d;
  logic                   locked_q, locked_d;
  logic [7:0]             err_cnt_q, err_cnt_d;
  logic                   ready;
  logic                   accept;
  logic                   match_all;

  assign output_clk       = input_clk;
  assign ready            = (state_q == IDLE);
  assign bus.cfg_ready    = ready;
  assign bus.output_valid = ready;
  assign bus.output_q     = out_q;
  assign bus.locked       = locked_q;
  assign bus.err_count    = err_cnt_q;

  // Tap 0 is the capture register itself, so a zero delay costs no shift stage.
  always_comb begin
    logic [BUS_W-1:0] word;
    word     = '0;
    cap_d    = bus.input_d;
    line_d[0] = cap_q;
    for (int j = 1; j < DMAX; j++) line_d[j] = line_q[j-1];
    tap_w[0] = cap_q;
    for (int j = 1; j <= DMAX; j++) tap_w[j] = line_q[j-1];
    out_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      word = tap_w[delay_q[i]];
      out_d[i*LANE_WIDTH +: LANE_WIDTH] = word[i*LANE_WIDTH +: LANE_WIDTH];
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    delay_d      = delay_q;
    accept       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cfg_valid) begin
          accept       = 1'b1;
          state_d      = SETTLE_ST;
          settle_cnt_d = SETTLE_INIT;
          for (int i = 0; i < CHANNELS; i++)
            delay_d[i] = bus.cfg_delay[i*DELAY_WIDTH +: DELAY_WIDTH];
        end
      end
      SETTLE_ST: begin
        if (settle_cnt_q == '0) state_d = IDLE;
        else                    settle_cnt_d = settle_cnt_q - 1'b1;
      end
      default: state_d = SETTLE_ST;
    endcase
  end

  // A config accept overrides any training outcome on the same edge, except err_count.
  always_comb begin
    match_all = 1'b1;
    for (int i = 0; i < CHANNELS; i++)
      if (out_q[i*LANE_WIDTH +: LANE_WIDTH] != TRAIN_PATTERN) match_all = 1'b0;
    match_cnt_d = match_cnt_q;
    locked_d    = locked_q;
    err_cnt_d   = err_cnt_q;
    if (bus.train_en && ready) begin
      if (match_all) begin
        if (match_cnt_q != LOCK_MAX) match_cnt_d = match_cnt_q + 8'd1;
        locked_d = (match_cnt_d == LOCK_MAX);
      end else begin
        match_cnt_d = '0;
        locked_d    = 1'b0;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
    end
    if (accept) begin
      match_cnt_d = '0;
      locked_d    = 1'b0;
    end
  end

  always_ff @(posedge input_clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q        <= '0;
      for (int j = 0; j < DMAX; j++) line_q[j] <= '0;
      out_q        <= '0;
      for (int i = 0; i < CHANNELS; i++) delay_q[i] <= '0;
      state_q      <= SETTLE_ST;
      settle_cnt_q <= SETTLE_INIT;
      match_cnt_q  <= '0;
      locked_q     <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      cap_q        <= cap_d;
      for (int j = 0; j < DMAX; j++) line_q[j] <= line_d[j];
      out_q        <= out_d;
      for (int i = 0; i < CHANNELS; i++) delay_q[i] <= delay_d[i];
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      match_cnt_q  <= match_cnt_d;
      locked_q     <= locked_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_ssio_sdr_in_deskew.sv
// Randomized and directed bench for ssio_sdr_in_deskew, checked every edge
// against a history-queue model of capture, delay taps, settle and training.
module tb_ssio_sdr_in_deskew;
  localparam int CH = 4;
  localparam int LW = 2;
  localparam int DW = 3;
  localparam int S  = 10;
  localparam int LOCKN = 16;
  localparam logic [7:0] PAT_WORD = 8'hAA;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic oclk;

  ssio_sdr_in_deskew_if #(.CHANNELS(CH), .LANE_WIDTH(LW), .DELAY_WIDTH(DW)) bus ();

  ssio_sdr_in_deskew #(
    .TARGET("SIM"), .CHANNELS(CH), .LANE_WIDTH(LW), .DELAY_WIDTH(DW),
    .TRAIN_PATTERN(2'b10), .LOCK_COUNT(LOCKN)
  ) dut (
    .input_clk(clk), .rst_n(rst_n), .output_clk(oclk), .bus(bus)
  );

  always #5 clk = ~clk;

  int check_cnt = 0;
  int pass_cnt  = 0;

  // Model state: hist[k] is the word captured k+1 edges ago; since counts edges since reset/accept.
  logic [7:0] hist[$];
  logic [7:0] exp_q;
  int since, run, err;
  int dly[CH];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic modelReset();
    hist.delete();
    for (int k = 0; k < 8; k++) hist.push_back(8'h00);
    exp_q = 8'h00;
    since = 0;
    run   = 0;
    err   = 0;
    for (int i = 0; i < CH; i++) dly[i] = 0;
  endtask

  task automatic checkAll();
    checkOutput("output_q", {24'h0, bus.output_q}, {24'h0, exp_q});
    checkOutput("output_valid", {31'h0, bus.output_valid}, {31'h0, since >= S});
    checkOutput("cfg_ready", {31'h0, bus.cfg_ready}, {31'h0, since >= S});
    checkOutput("locked", {31'h0, bus.locked}, {31'h0, run >= LOCKN});
    checkOutput("err_count", {24'h0, bus.err_count}, (err > 255) ? 32'd255 : 32'(err));
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic cv, input logic [11:0] cd, input logic te);
    logic       valid_b;
    logic       accept;
    logic [7:0] nq;
    logic [7:0] w;
    bus.input_d   = d;
    bus.cfg_valid = cv;
    bus.cfg_delay = cd;
    bus.train_en  = te;
    @(posedge clk);
    valid_b = (since >= S);
    accept  = cv && valid_b;
    if (te && valid_b) begin
      if (exp_q == PAT_WORD) run++;
      else begin
        run = 0;
        err++;
      end
    end
    if (accept) run = 0;
    nq = 8'h00;
    for (int i = 0; i < CH; i++) begin
      w = hist[dly[i]];
      nq[i*LW +: LW] = w[i*LW +: LW];
    end
    exp_q = nq;
    hist.push_front(d);
    void'(hist.pop_back());
    if (accept) begin
      for (int i = 0; i < CH; i++) dly[i] = int'(cd[i*DW +: DW]);
      since = 0;
    end else if (since < 1000) begin
      since++;
    end
    #1;
    checkAll();
  endtask

  task automatic applyReset(input int hold);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    repeat (hold) @(posedge clk);
    #1;
    checkAll();
    rst_n = 1'b1;
  endtask

  initial begin
    int acc;
    logic [7:0] d;
    logic [11:0] cd;
    logic noisy;
    bus.input_d   = '0;
    bus.cfg_delay = '0;
    bus.cfg_valid = 1'b0;
    bus.train_en  = 1'b0;
    modelReset();

    // Reset release and settle window
    applyReset(2);
    for (int k = 1; k <= S; k++) begin
      applyStimulus(8'($urandom), 1'b0, 12'h000, 1'b0);
      checkOutput("settle_valid", {31'h0, bus.output_valid}, {31'h0, k >= S});
    end
    checkOutput("output_clk", {31'h0, oclk}, {31'h0, clk});

    // Per-lane delays {lane3=1, lane2=7, lane1=3, lane0=0} and an impulse
    applyStimulus(8'h00, 1'b1, {3'd1, 3'd7, 3'd3, 3'd0}, 1'b0);
    repeat (S) applyStimulus(8'h00, 1'b0, 12'h000, 1'b0);
    applyStimulus(8'hFF, 1'b0, 12'h000, 1'b0);
    for (int k = 2; k <= 10; k++) begin
      applyStimulus(8'h00, 1'b0, 12'h000, 1'b0);
      checkOutput("impulse_l0", {30'h0, bus.output_q[1:0]}, (k == 2) ? 32'd3 : 32'd0);
      checkOutput("impulse_l1", {30'h0, bus.output_q[3:2]}, (k == 5) ? 32'd3 : 32'd0);
      checkOutput("impulse_l2", {30'h0, bus.output_q[5:4]}, (k == 9) ? 32'd3 : 32'd0);
      checkOutput("impulse_l3", {30'h0, bus.output_q[7:6]}, (k == 3) ? 32'd3 : 32'd0);
    end

    // cfg_valid held high: one accept per IDLE window
    acc = 0;
    for (int k = 0; k < 22; k++) begin
      if (bus.cfg_ready) acc++;
      applyStimulus(8'($urandom), 1'b1, 12'($urandom), 1'b0);
    end
    checkOutput("hold_accepts", 32'(acc), 32'd2);
    repeat (S) applyStimulus(8'h00, 1'b0, 12'h000, 1'b0);

    // Lock, then a single corrupted word
    applyReset(1);
    repeat (S) applyStimulus(PAT_WORD, 1'b0, 12'h000, 1'b0);
    repeat (LOCKN + 4) applyStimulus(PAT_WORD, 1'b0, 12'h000, 1'b1);
    checkOutput("lock_reached", {31'h0, bus.locked}, 32'd1);
    applyStimulus(8'h00, 1'b0, 12'h000, 1'b1);
    applyStimulus(PAT_WORD, 1'b0, 12'h000, 1'b1);
    applyStimulus(PAT_WORD, 1'b0, 12'h000, 1'b1);
    checkOutput("lock_lost", {31'h0, bus.locked}, 32'd0);
    checkOutput("err_one", {24'h0, bus.err_count}, 32'd1);

    // Error counter saturation
    repeat (300) applyStimulus(8'h00, 1'b0, 12'h000, 1'b1);
    checkOutput("err_sat", {24'h0, bus.err_count}, 32'hFF);
    repeat (5) applyStimulus(8'h00, 1'b0, 12'h000, 1'b1);
    checkOutput("err_sat_hold", {24'h0, bus.err_count}, 32'hFF);

    // Reset four edges into a settle window
    applyStimulus(8'h55, 1'b1, 12'hFFF, 1'b0);
    repeat (4) applyStimulus(8'($urandom), 1'b0, 12'h000, 1'b0);
    applyReset(1);
    checkOutput("rst_err", {24'h0, bus.err_count}, 32'd0);
    for (int k = 1; k <= S; k++) begin
      applyStimulus(8'($urandom), 1'b0, 12'h000, 1'b0);
      checkOutput("rst_settle_valid", {31'h0, bus.output_valid}, {31'h0, k >= S});
    end

    // Randomized segments: clean training bursts and noisy stretches with config churn
    for (int seg = 0; seg < 16; seg++) begin
      noisy = 1'($urandom_range(0, 1));
      for (int k = 0; k < 40; k++) begin
        d  = (noisy && ($urandom_range(0, 3) == 0)) ? 8'($urandom) : PAT_WORD;
        cd = 12'($urandom);
        applyStimulus(d, ($urandom_range(0, 24) == 0), cd, ($urandom_range(0, 9) != 0));
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
